alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 44 ++++
 rtl/alu_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants, FSM state type and operand-usage decode for the ALU sequencer.
package alu_sequencer_pkg;

  localparam logic [3:0] OP_PASS_A  = 4'b0000;
  localparam logic [3:0] OP_PASS_B  = 4'b0001;
  localparam logic [3:0] OP_NOT_A   = 4'b0010;
  localparam logic [3:0] OP_NOT_B   = 4'b0011;
  localparam logic [3:0] OP_ADD     = 4'b0100;
  localparam logic [3:0] OP_ADC     = 4'b0101;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_AND     = 4'b0111;
  localparam logic [3:0] OP_ZERO    = 4'b1000;
  localparam logic [3:0] OP_ONES    = 4'b1001;
  localparam logic [3:0] OP_GET_CY  = 4'b1010;
  localparam logic [3:0] OP_CLR_CY  = 4'b1011;
  localparam logic [3:0] OP_SET_CY  = 4'b1100;
  localparam logic [3:0] OP_CONST_D = 4'b1101;
  localparam logic [3:0] OP_CLEAR   = 4'b1110;
  localparam logic [3:0] OP_CONST_F = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_A,
    ST_LD_B,
    ST_EXEC,
    ST_DONE
  } state_e;

  function automatic logic uses_a(input logic [3:0] code);
    return (code == OP_PASS_A) || (code == OP_NOT_A) ||
           ((code >= OP_ADD) && (code <= OP_AND));
  endfunction

  function automatic logic uses_b(input logic [3:0] code);
    return (code == OP_PASS_B) || (code == OP_NOT_B) ||
           ((code >= OP_ADD) && (code <= OP_AND));
  endfunction

  // Flag-only ops leave the result register alone.
  function automatic logic writes_result(input logic [3:0] code);
    return (code != OP_CLR_CY) && (code != OP_SET_CY);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences operand loads from a shared bus into an external ALU and captures
// its result and carry; one operation in flight at a time.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] bus_in,
  output logic             bus_rd_a,
  output logic             bus_rd_b,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [3:0]       aluc,
  output logic             cy_in,
  input  logic [WIDTH-1:0] z,
  input  logic             cy_out,
  output logic [WIDTH-1:0] result,
  output logic             cy_flag,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]       aluc_q, aluc_d;
  logic             cy_q, cy_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             rd_a_q, rd_a_d, rd_b_q, rd_b_d;

  // Strobes are computed for the state being entered, so they are registered
  // yet high during exactly the LD_A / LD_B cycles.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    aluc_d   = aluc_q;
    result_d = result_q;
    cy_d     = cy_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    rd_a_d   = 1'b0;
    rd_b_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          aluc_d = op;
          busy_d = 1'b1;
          if (uses_a(op)) begin
            state_d = ST_LD_A;
            rd_a_d  = 1'b1;
          end else if (uses_b(op)) begin
            state_d = ST_LD_B;
            rd_b_d  = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_LD_A: begin
        a_d    = bus_in;
        busy_d = 1'b1;
        if (uses_b(aluc_q)) begin
          state_d = ST_LD_B;
          rd_b_d  = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_LD_B: begin
        b_d     = bus_in;
        busy_d  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (writes_result(aluc_q)) begin
          result_d = z;
        end
        case (aluc_q)
          OP_ADD, OP_ADC:                    cy_d = cy_out;
          OP_CLR_CY, OP_CONST_D, OP_CLEAR,
          OP_CONST_F:                        cy_d = 1'b0;
          OP_SET_CY:                         cy_d = 1'b1;
          default:                           cy_d = cy_q;
        endcase
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      aluc_q   <= '0;
      result_q <= '0;
      cy_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_a_q   <= 1'b0;
      rd_b_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluc_q   <= aluc_d;
      result_q <= result_d;
      cy_q     <= cy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_a_q   <= rd_a_d;
      rd_b_q   <= rd_b_d;
    end
  end

  assign bus_rd_a = rd_a_q;
  assign bus_rd_b = rd_b_q;
  assign a        = a_q;
  assign b        = b_q;
  assign aluc     = aluc_q;
  assign cy_in    = cy_q;
  assign result   = result_q;
  assign cy_flag  = cy_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural ALU drives z/cy_out, a
// reference model predicts each completed operation, and a monitor checks it.
module tb_alu_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] bus_in;
  logic         bus_rd_a, bus_rd_b;
  logic [W-1:0] a, b, z, result;
  logic [3:0]   aluc;
  logic         cy_in, cy_out, cy_flag, busy, done;

  logic [W-1:0] drv_a = '0;
  logic [W-1:0] drv_b = '0;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .bus_in(bus_in),
    .bus_rd_a(bus_rd_a), .bus_rd_b(bus_rd_b), .a(a), .b(b), .aluc(aluc),
    .cy_in(cy_in), .z(z), .cy_out(cy_out), .result(result),
    .cy_flag(cy_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External ALU: carry is only meaningful for adds; other ops report 1 so a
  // wrongly captured carry shows up.
  function automatic logic [W:0] alu_f(input logic [3:0] c, input logic [W-1:0] x,
                                       input logic [W-1:0] y, input logic ci);
    logic [W:0] s;
    case (c)
      4'd0:  return {1'b1, x};
      4'd1:  return {1'b1, y};
      4'd2:  return {1'b1, ~x};
      4'd3:  return {1'b1, ~y};
      4'd4:  begin s = {1'b0, x} + {1'b0, y}; return s; end
      4'd5:  begin s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci}; return s; end
      4'd6:  return {1'b1, x - y};
      4'd7:  return {1'b1, x & y};
      4'd8:  return {1'b1, {W{1'b0}}};
      4'd9:  return {1'b1, {W{1'b1}}};
      4'd10: return {1'b1, {(W-1){1'b0}}, ci};
      4'd13: return {1'b1, 16'h5555};
      4'd14: return {1'b1, {W{1'b0}}};
      4'd15: return {1'b1, 16'hAAAA};
      default: return {1'b1, x ^ y};
    endcase
  endfunction

  always_comb {cy_out, z} = alu_f(aluc, a, b, cy_in);
  always_comb bus_in = bus_rd_a ? drv_a : (bus_rd_b ? drv_b : 16'hDEAD);

  function automatic bit t_ua(input logic [3:0] c);
    return (c == 4'd0) || (c == 4'd2) || (c >= 4'd4 && c <= 4'd7);
  endfunction
  function automatic bit t_ub(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd3) || (c >= 4'd4 && c <= 4'd7);
  endfunction

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] res, ea, eb;
    logic         cy;
    int           done_cyc, na, nb;
  } item_t;

  item_t        sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic         m_cy = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops one expectation per done pulse.
  initial begin
    item_t it;
    int    seen_a, seen_b;
    seen_a = 0;
    seen_b = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen_a = 0;
        seen_b = 0;
      end else begin
        if (bus_rd_a && bus_rd_b) check("strobe_overlap", 16'(bus_rd_a & bus_rd_b), 16'h0);
        seen_a += int'(bus_rd_a);
        seen_b += int'(bus_rd_b);
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
          end else begin
            it = sb.pop_front();
            check("result", result, it.res);
            check("cy_flag", 16'(cy_flag), 16'(it.cy));
            check("reg_a", a, it.ea);
            check("reg_b", b, it.eb);
            check("aluc", 16'(aluc), 16'(it.op));
            check("done_cycle", 16'(cyc), 16'(it.done_cyc));
            check("rd_a_count", 16'(seen_a), 16'(it.na));
            check("rd_b_count", 16'(seen_b), 16'(it.nb));
            check("busy_in_done", 16'(busy), 16'h0);
            $display("op=%b a=%h b=%h -> result=%h cy=%0d (exp %h/%0d) at cycle %0d",
                     it.op, it.ea, it.eb, result, cy_flag, it.res, it.cy, cyc);
          end
          seen_a = 0;
          seen_b = 0;
        end
      end
    end
  end

  task automatic do_op(input logic [3:0] c, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input bit poke);
    item_t      it;
    logic [W:0] r;
    int         k, n, waited;
    bit         got;
    @(negedge clk);
    drv_a = va;
    drv_b = vb;
    op    = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    k     = cyc;
    start = 1'b0;
    op    = $urandom_range(0, 15);
    if (t_ua(c)) m_a = va;
    if (t_ub(c)) m_b = vb;
    r = alu_f(c, m_a, m_b, m_cy);
    if (c != 4'd11 && c != 4'd12) m_res = r[W-1:0];
    case (c)
      4'd4, 4'd5:                  m_cy = r[W];
      4'd11, 4'd13, 4'd14, 4'd15:  m_cy = 1'b0;
      4'd12:                       m_cy = 1'b1;
      default:                     m_cy = m_cy;
    endcase
    n = int'(t_ua(c)) + int'(t_ub(c));
    it.op = c; it.res = m_res; it.cy = m_cy; it.ea = m_a; it.eb = m_b;
    it.done_cyc = k + n + 1;
    it.na = int'(t_ua(c));
    it.nb = int'(t_ub(c));
    sb.push_back(it);
    check("busy_after_accept", 16'(busy), 16'h1);
    if (poke) begin
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      op    = 4'd14;
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
    end
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 12) begin
      @(negedge clk);
      waited++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done for op=%b", c);
      sb.delete();
    end
  endtask

  task automatic reset_during_exec();
    item_t it;
    @(negedge clk);
    drv_a = $urandom;
    drv_b = $urandom;
    op    = 4'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("in_exec_busy", 16'(busy), 16'h1);
    rst_n = 1'b0;
    #1;
    check("rst_a", a, 16'h0);
    check("rst_b", b, 16'h0);
    check("rst_result", result, 16'h0);
    check("rst_aluc", 16'(aluc), 16'h0);
    check("rst_ctrl", {11'h0, cy_flag, busy, done, bus_rd_a, bus_rd_b}, 16'h0);
    m_a = '0; m_b = '0; m_res = '0; m_cy = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rc;
    repeat (2) @(posedge clk);
    #1;
    check("init_result", result, 16'h0);
    check("init_ab", a | b, 16'h0);
    check("init_ctrl", {7'h0, aluc, cy_flag, busy, done, bus_rd_a, bus_rd_b}, 16'h0);
    rst_n = 1'b1;

    do_op(4'b0100, 16'hFFFF, 16'h0001, 1'b0);
    check("add_result", result, 16'h0000);
    check("add_cy", 16'(cy_flag), 16'h1);
    do_op(4'b0101, 16'h0001, 16'h0001, 1'b0);
    check("adc_result", result, 16'h0003);
    check("adc_cy", 16'(cy_flag), 16'h0);
    do_op(4'b0010, 16'h00F0, 16'h7777, 1'b0);
    check("nota_result", result, 16'hFF0F);
    check("nota_b_held", b, 16'h0001);
    do_op(4'b0000, 16'h1234, 16'h0000, 1'b0);
    do_op(4'b1100, 16'h5A5A, 16'hA5A5, 1'b0);
    check("setcy_result", result, 16'h1234);
    check("setcy_cy", 16'(cy_flag), 16'h1);
    do_op(4'b0110, 16'h0010, 16'h0003, 1'b1);
    check("sub_result", result, 16'h000D);
    do_op(4'b1110, 16'h4444, 16'h3333, 1'b0);
    check("clear_result", result, 16'h0000);
    check("clear_cy", 16'(cy_flag), 16'h0);

    reset_during_exec();
    do_op(4'b0100, 16'h0102, 16'h0304, 1'b0);
    check("post_reset_result", result, 16'h0406);

    for (int i = 0; i < 200; i++) begin
      rc = 4'($urandom_range(0, 15));
      do_op(rc, 16'($urandom), 16'($urandom),
            (rc >= 4'd4 && rc <= 4'd7) && ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
